// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: the program is streamed in through a load port, then
// fetched with one cycle of latency. Out-of-range fetches return NOP_WORD and raise a fault.
module instruction_memory_loadable #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       ADDR_W   = 10,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow,
    output logic              mem_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              addr_fault
);

    localparam int unsigned   IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StEmpty, StLoading, StReady} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     wptr_q, wptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wptr_q[IDX_W-1:0];

        // A restart on the same edge suppresses the fetch so entry to LOADING sees valid=0.
        if (state_q == StReady && fetch_en && !load_start) begin
            valid_d = 1'b1;
            if ({1'b0, fetch_addr} < count_q) begin
                instr_d = mem_q[fetch_addr[IDX_W-1:0]];
            end else begin
                instr_d = NOP_WORD;
                fault_d = 1'b1;
            end
        end

        if (load_start) begin
            state_d = StLoading;
            wptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                StLoading: begin
                    if (load_valid) begin
                        if (wptr_q < FULL) begin
                            mem_we = 1'b1;
                            wptr_d = wptr_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (load_last) begin
                            state_d = StReady;
                            count_d = (wptr_q < FULL) ? wptr_q + 1'b1 : wptr_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= load_data;
        end
    end

    assign load_ready    = (state_q == StLoading);
    assign mem_ready     = (state_q == StReady);
    assign load_count    = count_q;
    assign load_overflow = ovf_q;
    assign instr_out     = instr_q;
    assign instr_valid   = valid_q;
    assign addr_fault    = fault_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Bench for instruction_memory_loadable: a queue-based program model checked every cycle,
// plus literal expectations from directed load/fetch sequences (DEPTH=4 to reach overflow).
module tb_instruction_memory_loadable;

    localparam int unsigned       DATA_W = 32;
    localparam int unsigned       DEPTH  = 4;
    localparam int unsigned       ADDR_W = 10;
    localparam logic [DATA_W-1:0] NOP    = 32'h0;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_start, load_valid, load_last, fetch_en;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W-1:0] fetch_addr;
    logic              load_ready, load_overflow, mem_ready, instr_valid, addr_fault;
    logic [ADDR_W:0]   load_count;
    logic [DATA_W-1:0] instr_out;

    int n_checks = 0;
    int n_errors = 0;

    instruction_memory_loadable #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NOP_WORD(NOP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_count   (load_count),
        .load_overflow(load_overflow),
        .mem_ready    (mem_ready),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .addr_fault   (addr_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: 0 empty, 1 loading, 2 ready; the stored program is simply a queue.
    int                m_phase = 0;
    logic [DATA_W-1:0] m_prog[$];
    int                m_count = 0;
    logic              m_ovf   = 1'b0;
    logic [DATA_W-1:0] m_instr = '0;
    logic              m_valid = 1'b0;
    logic              m_fault = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_count <= 0;
            m_ovf   <= 1'b0;
            m_instr <= '0;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
            m_prog.delete();
        end else begin
            m_valid <= 1'b0;
            m_fault <= 1'b0;
            if (m_phase == 2 && fetch_en && !load_start) begin
                m_valid <= 1'b1;
                if (int'(fetch_addr) < m_count) begin
                    m_instr <= m_prog[fetch_addr];
                end else begin
                    m_instr <= NOP;
                    m_fault <= 1'b1;
                end
            end
            if (load_start) begin
                m_phase <= 1;
                m_count <= 0;
                m_ovf   <= 1'b0;
                m_prog.delete();
            end else if (m_phase == 1 && load_valid) begin
                if (m_prog.size() < DEPTH) m_prog.push_back(load_data);
                else m_ovf <= 1'b1;
                if (load_last) begin
                    m_phase <= 2;
                    m_count <= m_prog.size();
                end
            end
        end
    end

    always @(negedge clock) begin
        #1;
        check("load_ready",    load_ready,    m_phase == 1);
        check("mem_ready",     mem_ready,     m_phase == 2);
        check("load_count",    load_count,    m_count);
        check("load_overflow", load_overflow, m_ovf);
        check("instr_valid",   instr_valid,   m_valid);
        check("addr_fault",    addr_fault,    m_fault);
        check("instr_out",     instr_out,     m_instr);
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic beat(input logic [DATA_W-1:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] addr);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        step();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        step();
        step();

        // T1: reset values; a fetch while EMPTY is ignored
        check("t1_instr_out", instr_out, 0);
        check("t1_load_ready", load_ready, 0);
        reset = 1'b1;
        fetch(10'd0);
        step();
        check("t1_valid", instr_valid, 0);
        check("t1_count", load_count, 0);
        fetch_en = 1'b0;

        // T2: three-word program
        start_load();
        check("t2_load_ready", load_ready, 1);
        beat(32'h3800_0035, 1'b0);
        beat(32'h8000_0000, 1'b0);
        beat(32'h0000_0000, 1'b1);
        check("t2_count", load_count, 3);
        check("t2_mem_ready", mem_ready, 1);
        fetch(10'd1);
        check("t2_instr", instr_out, 32'h8000_0000);
        check("t2_valid", instr_valid, 1);
        fetch(10'd0);
        check("t2_instr0", instr_out, 32'h3800_0035);

        // T3: unloaded and far out-of-range addresses
        fetch(10'd3);
        check("t3_fault3", addr_fault, 1);
        check("t3_nop3", instr_out, NOP);
        fetch(10'd0);
        fetch(10'd1023);
        check("t3_fault1023", addr_fault, 1);
        check("t3_nop1023", instr_out, NOP);
        fetch(10'd1);
        fetch_en = 1'b0;
        step();
        check("t3_idle_valid", instr_valid, 0);
        check("t3_hold", instr_out, 32'h8000_0000);

        // T4: six beats into four words
        start_load();
        for (int i = 1; i <= 6; i++) beat(32'(i * 17), i == 6);
        check("t4_overflow", load_overflow, 1);
        check("t4_count", load_count, 4);
        fetch(10'd3);
        check("t4_mem3", instr_out, 32'h44);
        fetch(10'd4);
        check("t4_fault4", addr_fault, 1);
        fetch_en = 1'b0;

        // T5: restart coincident with beat 2, then a 2-word load
        start_load();
        beat(32'hA1A1_0001, 1'b0);
        load_start = 1'b1;
        beat(32'hA1A1_0002, 1'b0);
        load_start = 1'b0;
        check("t5_ovf_cleared", load_overflow, 0);
        beat(32'hB2B2_0001, 1'b0);
        beat(32'hB2B2_0002, 1'b1);
        check("t5_count", load_count, 2);
        fetch(10'd0);
        check("t5_instr0", instr_out, 32'hB2B2_0001);
        fetch(10'd1);
        check("t5_instr1", instr_out, 32'hB2B2_0002);
        fetch(10'd2);
        check("t5_fault2", addr_fault, 1);

        // Restart from READY with a fetch pending
        load_start = 1'b1;
        fetch(10'd0);
        load_start = 1'b0;
        check("restart_valid", instr_valid, 0);
        fetch_en = 1'b0;
        beat(32'hCAFE_0000, 1'b1);

        // T6: reset between load beats
        start_load();
        beat(32'hC0DE_0001, 1'b0);
        reset = 1'b0;
        step();
        check("t6_mem_ready", mem_ready, 0);
        check("t6_count", load_count, 0);
        reset = 1'b1;
        fetch(10'd0);
        step();
        check("t6_fetch_ignored", instr_valid, 0);
        fetch_en = 1'b0;
        start_load();
        beat(32'hC0DE_0011, 1'b0);
        beat(32'hC0DE_0022, 1'b1);
        fetch(10'd1);
        check("t6_reload_instr", instr_out, 32'hC0DE_0022);
        check("t6_reload_valid", instr_valid, 1);
        fetch_en = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
